// File: rtl/metro_pkg.sv
// -----------------------------------------------------------------------------
// metro_pkg
//   Shared definitions for the metro card-reader front end and anything that
//   decodes its debug state (e.g. the turnstile controller).
//   Contents:
//     - state_t             : framer FSM state encoding (IDLE/DATA/PARITY/STOP)
//     - DEFAULT_CODE_WIDTH  : default number of data bits per frame
//     - START_BIT/STOP_BIT  : bit-level line values for frame delimiters
//     - even_parity_ok()    : even-parity check over data XOR + parity bit
// -----------------------------------------------------------------------------
package metro_pkg;

    localparam int DEFAULT_CODE_WIDTH = 4;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DATA   = 2'b01,
        ST_PARITY = 2'b10,
        ST_STOP   = 2'b11
    } state_t;

    // Even parity: XOR of all data bits together with the parity bit must be 0.
    function automatic logic even_parity_ok(input logic data_xor, input logic parity_bit);
        return (data_xor ^ parity_bit) == 1'b0;
    endfunction

endpackage

// File: rtl/bit_gap_timer.sv
// -----------------------------------------------------------------------------
// bit_gap_timer
//   Counts strobe-free clock cycles while a frame is in progress and flags the
//   cycle in which the gap would reach TIMEOUT_CYCLES.
//   Ports:
//     clk      in  system clock
//     reset    in  synchronous active-high reset
//     clear    in  a strobe arrived this cycle; restart the gap count
//     enable   in  a frame is in progress (framer state != IDLE)
//     expired  out high for the one cycle whose closing edge completes the
//                  TIMEOUT_CYCLES-th strobe-free cycle
// -----------------------------------------------------------------------------
module bit_gap_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset || clear || !enable) begin
            count_reg <= '0;
        end else if (count_reg != CNT_W'(TIMEOUT_CYCLES)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // Combinational look-ahead: the framer acts on the same edge that moves the
    // count to TIMEOUT_CYCLES. A strobe in that cycle clears instead, so the
    // strobe wins over the timeout.
    assign expired = enable && !clear && (count_reg == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/metro_card_reader.sv
// -----------------------------------------------------------------------------
// metro_card_reader
//   Serial framer for the turnstile card-reader head. Frames are, in strobe
//   order: start(0), CODE_WIDTH data bits LSB first, even parity bit, stop(1).
//   Good frames load access_code and pulse validate_code; bad parity pulses
//   parity_error; bad stop bit or a mid-frame stall pulses frame_error.
//   Ports:
//     clk            in   system clock, rising edge
//     reset          in   synchronous active-high reset
//     card_bit       in   serial data, valid only with bit_strobe
//     bit_strobe     in   one-cycle qualifier for card_bit
//     access_code    out  last good code, held until the next good frame
//     validate_code  out  one-cycle pulse, access_code is new
//     parity_error   out  one-cycle pulse, frame dropped for parity
//     frame_error    out  one-cycle pulse, bad stop bit or timeout
//     busy           out  frame in progress
//     state_out      out  debug copy of the FSM state
// -----------------------------------------------------------------------------
module metro_card_reader
    import metro_pkg::*;
#(
    parameter int CODE_WIDTH     = DEFAULT_CODE_WIDTH,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  card_bit,
    input  logic                  bit_strobe,
    output logic [CODE_WIDTH-1:0] access_code,
    output logic                  validate_code,
    output logic                  parity_error,
    output logic                  frame_error,
    output logic                  busy,
    output logic [1:0]            state_out
);

    localparam int IDX_W = (CODE_WIDTH > 1) ? $clog2(CODE_WIDTH) : 1;

    state_t                state_reg, state_next;
    logic [IDX_W-1:0]      bit_count_reg, bit_count_next;
    logic [CODE_WIDTH-1:0] shift_reg, shift_next;
    logic                  parity_ok_reg, parity_ok_next;
    logic [CODE_WIDTH-1:0] access_code_reg, access_code_next;
    logic                  validate_reg, validate_next;
    logic                  parity_error_reg, parity_error_next;
    logic                  frame_error_reg, frame_error_next;

    logic                  frame_active;
    logic                  timer_expired;
    logic                  last_data_bit;
    logic [CODE_WIDTH-1:0] bit_sel;

    assign frame_active  = (state_reg != ST_IDLE);
    assign last_data_bit = (bit_count_reg == IDX_W'(CODE_WIDTH - 1));

    // One-hot select of the shift-register position written by the current
    // data strobe.
    generate
        for (genvar gi = 0; gi < CODE_WIDTH; gi++) begin : g_bit_sel
            assign bit_sel[gi] = (bit_count_reg == IDX_W'(gi));
        end
    endgenerate

    bit_gap_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (bit_strobe),
        .enable  (frame_active),
        .expired (timer_expired)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            bit_count_reg    <= '0;
            shift_reg        <= '0;
            parity_ok_reg    <= 1'b0;
            access_code_reg  <= '0;
            validate_reg     <= 1'b0;
            parity_error_reg <= 1'b0;
            frame_error_reg  <= 1'b0;
        end else begin
            state_reg        <= state_next;
            bit_count_reg    <= bit_count_next;
            shift_reg        <= shift_next;
            parity_ok_reg    <= parity_ok_next;
            access_code_reg  <= access_code_next;
            validate_reg     <= validate_next;
            parity_error_reg <= parity_error_next;
            frame_error_reg  <= frame_error_next;
        end
    end

    // Next-state logic. The gap timer only fires on strobe-free cycles, so a
    // timeout never competes with a strobe-driven transition.
    always_comb begin
        state_next = state_reg;
        if (timer_expired) begin
            state_next = ST_IDLE;
        end else if (bit_strobe) begin
            case (state_reg)
                ST_IDLE:   if (card_bit == START_BIT) state_next = ST_DATA;
                ST_DATA:   if (last_data_bit)         state_next = ST_PARITY;
                ST_PARITY: state_next = ST_STOP;
                ST_STOP:   state_next = ST_IDLE;
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    // Datapath and pulse outputs (registered above).
    always_comb begin
        bit_count_next    = bit_count_reg;
        shift_next        = shift_reg;
        parity_ok_next    = parity_ok_reg;
        access_code_next  = access_code_reg;
        validate_next     = 1'b0;
        parity_error_next = 1'b0;
        frame_error_next  = 1'b0;

        if (timer_expired) begin
            // Stalled frame: drop it; partial data is overwritten by the next start.
            frame_error_next = 1'b1;
        end else if (bit_strobe) begin
            case (state_reg)
                ST_IDLE: begin
                    if (card_bit == START_BIT) begin
                        bit_count_next = '0;
                        shift_next     = '0;
                    end
                end
                ST_DATA: begin
                    shift_next     = (shift_reg & ~bit_sel) | ({CODE_WIDTH{card_bit}} & bit_sel);
                    bit_count_next = bit_count_reg + 1'b1;
                end
                ST_PARITY: begin
                    parity_ok_next = even_parity_ok(^shift_reg, card_bit);
                end
                ST_STOP: begin
                    // Stop-bit error takes precedence over a parity error.
                    if (card_bit != STOP_BIT) begin
                        frame_error_next = 1'b1;
                    end else if (!parity_ok_reg) begin
                        parity_error_next = 1'b1;
                    end else begin
                        validate_next    = 1'b1;
                        access_code_next = shift_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    assign access_code   = access_code_reg;
    assign validate_code = validate_reg;
    assign parity_error  = parity_error_reg;
    assign frame_error   = frame_error_reg;
    assign busy          = frame_active;
    assign state_out     = state_reg;

endmodule

// File: doc/metro_card_reader.md
# metro_card_reader

Front-end framer for the metro turnstile gate. It accepts a strobed serial bit stream from the card-reader head and checks each frame for start, parity and stop bits. Each good frame becomes a 4-bit access code plus a single-cycle `validate_code` pulse, wired directly to the turnstile FSM's `access_code` / `validate_code` inputs. Malformed or stalled frames are dropped and flagged.

## Interface
- `CODE_WIDTH`, 4, number of data bits per frame; equals the width of `access_code`.
- `TIMEOUT_CYCLES`, 16, maximum number of strobe-free clock cycles allowed mid-frame before the frame is aborted.

Ports:
- `clk`  input  1  single system clock; all logic on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `card_bit`  input  1  serial data from the reader head; sampled only when `bit_strobe` = 1.
- `bit_strobe`  input  1  one-cycle qualifier marking `card_bit` valid.
- `access_code`  output  CODE_WIDTH  last successfully received code; held until the next good frame.
- `validate_code`  output  1  one-cycle pulse; `access_code` is new and valid.
- `parity_error`  output  1  one-cycle pulse; frame dropped for bad parity.
- `frame_error`  output  1  one-cycle pulse; frame dropped for bad stop bit or timeout.
- `busy`  output  1  high while a frame is in progress (state ≠ IDLE).
- `state_out`  output  2  debug copy of the FSM state.

## Operation
- Frame format, in strobe order:
  - start bit = 0;
  - CODE_WIDTH data bits, LSB first;
  - 1 parity bit, even parity over data + parity;
  - stop bit = 1.
- FSM states and encodings: IDLE=2'b00, DATA=2'b01, PARITY=2'b10, STOP=2'b11.
- IDLE:
  - a strobe with `card_bit`=1 is idle line and is ignored;
  - a strobe with `card_bit`=0 moves to DATA and clears the bit counter and shift register.
- DATA: each strobe shifts `card_bit` into position [count]. After the CODE_WIDTH-th data strobe, move to PARITY.
- PARITY: the strobe stores parity-ok = (XOR of data bits ^ `card_bit`) == 0, then moves to STOP.
- STOP: the strobe returns to IDLE and raises exactly one of three pulses:
  - `card_bit`=0 → `frame_error`;
  - else parity bad → `parity_error`;
  - else → `validate_code`, and `access_code` loads the shift register.
- Errors never modify `access_code`.
- Timeout:
  - a gap counter clears on every strobe and increments on every strobe-free cycle while state ≠ IDLE;
  - when it reaches TIMEOUT_CYCLES: `frame_error` pulse, return to IDLE, partial data discarded.
  - If a strobe arrives on the cycle the counter would expire, the strobe wins and no timeout occurs.
- At most one of `validate_code`, `parity_error`, `frame_error` is high in any cycle.

## Timing
- All outputs are registered.
- Reset values: `access_code`=0, `validate_code`=0, `parity_error`=0, `frame_error`=0, `busy`=0, `state_out`=2'b00.
- Latency: pulses assert in the cycle immediately after the edge that samples the stop-bit strobe, and last exactly 1 cycle.
  - `access_code` changes on that same edge.
  - `busy` falls on that same edge.
- Timeout `frame_error` asserts on the edge where the gap count reaches TIMEOUT_CYCLES, i.e. TIMEOUT_CYCLES edges after the last accepted strobe.
- Minimum frame length: CODE_WIDTH+3 strobes (7 for the default). Strobes may arrive on consecutive cycles.
- A start-bit strobe arriving in the cycle immediately after a stop-bit strobe begins a new frame; back-to-back frames are supported.
- `reset` asserted mid-frame: the next edge returns the block to IDLE with all reset values and no error pulse.

## Structure
- Shared package `metro_pkg`, holding:
  - the FSM state typedef and encodings (shared with the turnstile's debug decoding);
  - the `CODE_WIDTH` default;
  - the START/STOP bit-level constants.
- One sub-module, `bit_gap_timer`:
  - parameterised by TIMEOUT_CYCLES;
  - inputs: clear (on strobe), enable (state ≠ IDLE), `reset`;
  - output: one-cycle `expired`;
  - counter width $clog2(TIMEOUT_CYCLES+1).

## Test plan
- Good frame: strobes 0, 1,0,0,1, 0, 1 (code 4'b1001, parity 0) → `validate_code` one cycle after the stop strobe, `access_code`=4'd9, `busy` back to 0.
- Bad parity: the same frame with parity bit 1 → `parity_error` for one cycle; `access_code` stays 9; no `validate_code`.
- Bad stop: a valid code 4'b0011 with stop bit 0 → `frame_error` for one cycle; `access_code` unchanged.
- Timeout: start bit plus 2 data bits, then 16 strobe-free cycles → `frame_error` on the 16th edge, `state_out`=00. A strobe on the 15th gap cycle instead → no error.
- Reset mid-frame: assert `reset` during DATA → all outputs at reset values next cycle, no pulses. A following full frame for code 4'hF (parity 0) → `access_code`=4'hF.
- Idle and back-to-back:
  - 5 strobes with `card_bit`=1 in IDLE → no state change;
  - then two back-to-back frames, code 5 then code 10 → two `validate_code` pulses 7 cycles apart, `access_code` 5 then 10.
